// File: rtl/mdsa_if.sv
// Bus between the loader/consumer and the 4x4 sorting array core.
//
// Handshake: the core raises rdy only while IDLE. An enabled clock edge that
// sees rdy=1 and start=1 captures data_in as row 0, and the next three
// enabled edges capture rows 1-3 regardless of start. Sorted rows come back
// one per enabled edge while output_enable=1. There is no backpressure from
// the consumer; en=0 freezes the whole core, including the output window.
// dbg_state mirrors the core FSM state for checkers.
interface mdsa_if #(
  parameter int W = 8
);
  logic           en;
  logic           start;
  logic [4*W-1:0] data_in;
  logic           rdy;
  logic           output_enable;
  logic [4*W-1:0] data_out;
  logic [1:0]     dbg_state;

  modport master (
    output en, start, data_in,
    input  rdy, output_enable, data_out, dbg_state
  );

  modport slave (
    input  en, start, data_in,
    output rdy, output_enable, data_out, dbg_state
  );
endinterface

// File: rtl/mdsa_top.sv
// 4x4 multidimensional sorting array. Loads four rows, runs five shearsort
// phases (row, column, row, column, row) with a 4-input bitonic network per
// line, then streams the rows out with odd rows reversed so that the whole
// stream is ascending.
module mdsa_top #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  mdsa_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [W-1:0]   m_q [4][4];
  logic [W-1:0]   m_d [4][4];
  logic           oe_q, oe_d;
  logic [4*W-1:0] dout_q, dout_d;

  // Compare-exchange network for one line of four elements: sort the two
  // halves in opposite directions to form a bitonic sequence, then merge.
  // Descending order is obtained by reading the ascending result backwards.
  function automatic logic [4*W-1:0] sort4(input logic [4*W-1:0] v,
                                           input logic desc);
    logic [W-1:0]   a [4];
    logic [W-1:0]   t;
    logic [4*W-1:0] r;
    for (int i = 0; i < 4; i++) a[i] = v[W*i +: W];
    // stage 1: (0,1) ascending, (2,3) descending
    if (a[0] > a[1]) begin t = a[0]; a[0] = a[1]; a[1] = t; end
    if (a[2] < a[3]) begin t = a[2]; a[2] = a[3]; a[3] = t; end
    // stage 2: half-cleaner across distance 2
    if (a[0] > a[2]) begin t = a[0]; a[0] = a[2]; a[2] = t; end
    if (a[1] > a[3]) begin t = a[1]; a[1] = a[3]; a[3] = t; end
    // stage 3: adjacent pairs
    if (a[0] > a[1]) begin t = a[0]; a[0] = a[1]; a[1] = t; end
    if (a[2] > a[3]) begin t = a[2]; a[2] = a[3]; a[3] = t; end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[W*i +: W] = desc ? a[3-i] : a[i];
    end
    return r;
  endfunction

  // FSM state and phase/row counter; en=0 holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else if (bus.en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: 1 edge in IDLE, 3 in LOAD, 5 in SORT, 5 in OUT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = 3'd1;
        end
      end
      LOAD: begin
        if (cnt_q == 3'd3) begin
          state_d = SORT;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      SORT: begin
        if (cnt_q == 3'd4) begin
          state_d = OUT;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      OUT: begin
        if (cnt_q == 3'd4) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Datapath next values: row capture, one sort phase per edge, output rows.
  always_comb begin
    logic [4*W-1:0] line;
    m_d    = m_q;
    oe_d   = oe_q;
    dout_d = dout_q;
    line   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int c = 0; c < 4; c++) m_d[0][c] = bus.data_in[W*c +: W];
        end
      end
      LOAD: begin
        for (int c = 0; c < 4; c++) m_d[cnt_q[1:0]][c] = bus.data_in[W*c +: W];
      end
      SORT: begin
        if (!cnt_q[0]) begin
          // Row phase (counter 0, 2, 4): snake direction, odd rows descend.
          for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) line[W*c +: W] = m_q[r][c];
            line = sort4(line, (r % 2) != 0);
            for (int c = 0; c < 4; c++) m_d[r][c] = line[W*c +: W];
          end
        end else begin
          // Column phase (counter 1, 3): ascending top to bottom.
          for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) line[W*r +: W] = m_q[r][c];
            line = sort4(line, 1'b0);
            for (int r = 0; r < 4; r++) m_d[r][c] = line[W*r +: W];
          end
        end
      end
      OUT: begin
        if (cnt_q == 3'd4) begin
          // Close the window; data_out keeps the last row.
          oe_d = 1'b0;
        end else begin
          oe_d = 1'b1;
          for (int c = 0; c < 4; c++) begin
            dout_d[W*c +: W] = cnt_q[0] ? m_q[cnt_q[1:0]][3-c]
                                        : m_q[cnt_q[1:0]][c];
          end
        end
      end
      default: ;
    endcase
  end

  // Matrix and output registers; cleared by reset, frozen by en=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) m_q[r][c] <= '0;
      end
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else if (bus.en) begin
      m_q    <= m_d;
      oe_q   <= oe_d;
      dout_q <= dout_d;
    end
  end

  assign bus.rdy           = (state_q == IDLE);
  assign bus.output_enable = oe_q;
  assign bus.data_out      = dout_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_mdsa_top.sv
// Self-checking bench for mdsa_top: directed vectors, back-to-back random
// sets, stalls, start misuse and reset abort. A driver pushes expected rows
// and window lengths; a monitor pops and compares on each new output row.
module tb_mdsa_top;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdsa_if #(.W(W)) bus ();

  mdsa_top #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [4*W-1:0] exp_q[$];
  int             len_q[$];
  logic [4*W-1:0] in_rows [4];
  logic [W-1:0]   vals [16];
  int             oe_rises = 0;

  function automatic logic [4*W-1:0] pack4(input logic [W-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [4*W-1:0] act,
                       input logic [4*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(output bit ok);
    int n = 0;
    while (!bus.rdy && n < 100) begin
      tick();
      n++;
    end
    ok = bus.rdy;
    if (!ok) check("rdy_timeout", 32'(bus.rdy), 32'd1);
  endtask

  // Loads in_rows. start is held for start_cycles enabled edges; stall_load
  // dead cycles are inserted before row 2, stall_out inside the output window.
  task automatic load_set(input int start_cycles, input int stall_load,
                          input int stall_out, input bit expect_out);
    bit ok;
    wait_rdy(ok);
    if (!ok) return;
    bus.start = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if (r == 2 && stall_load > 0) begin
        bus.data_in = in_rows[2];
        bus.en = 1'b0;
        repeat (stall_load) tick();
        bus.en = 1'b1;
      end
      bus.data_in = in_rows[r];
      if (r >= start_cycles) bus.start = 1'b0;
      tick();
    end
    bus.start = 1'b0;
    if (expect_out) len_q.push_back(4 + stall_out);
    if (stall_out > 0) begin
      repeat (7) tick();
      bus.en = 1'b0;
      repeat (stall_out) tick();
      bus.en = 1'b1;
    end
  endtask

  task automatic vals_to_rows();
    for (int r = 0; r < 4; r++)
      in_rows[r] = pack4(vals[4*r], vals[4*r+1], vals[4*r+2], vals[4*r+3]);
  endtask

  // Reference: plain insertion sort of the 16 loaded values.
  task automatic push_sorted();
    logic [W-1:0] s [16];
    logic [W-1:0] t;
    s = vals;
    for (int i = 1; i < 16; i++) begin
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    end
    for (int r = 0; r < 4; r++)
      exp_q.push_back(pack4(s[4*r], s[4*r+1], s[4*r+2], s[4*r+3]));
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.rdy) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("done_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
  endtask

  // ---------------- monitor ----------------
  logic           en_s = 1'b1;
  logic           oe_prev = 1'b0;
  int             burst_len = 0;
  logic [4*W-1:0] last_row = '0;

  always @(posedge clk) en_s <= bus.en;

  always @(negedge clk) begin
    if (!rst) begin
      oe_prev   = 1'b0;
      burst_len = 0;
    end else begin
      if (bus.output_enable && !oe_prev) oe_rises++;
      if (bus.output_enable && en_s) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row actual=%h expected=none", bus.data_out);
        end else begin
          last_row = exp_q.pop_front();
          check("row", bus.data_out, last_row);
        end
      end
      if (bus.output_enable) burst_len++;
      if (!bus.output_enable && oe_prev) begin
        if (len_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window actual=%0d expected=none", burst_len);
        end else begin
          check("window_len", 32'(burst_len), 32'(len_q.pop_front()));
        end
        check("rdy_after_out", 32'(bus.rdy), 32'd1);
        check("dout_hold", bus.data_out, last_row);
        burst_len = 0;
      end
      oe_prev = bus.output_enable;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int rises0;
    bus.en = 1'b1;
    bus.start = 1'b0;
    bus.data_in = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", 32'(bus.rdy), 32'd1);
    check("reset_oe", 32'(bus.output_enable), 32'd0);
    check("reset_dout", bus.data_out, '0);
    check("reset_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b1;
    tick();

    // Reverse input, start held 4 cycles; latency to first row.
    in_rows[0] = pack4(15, 14, 13, 12);
    in_rows[1] = pack4(11, 10, 9, 8);
    in_rows[2] = pack4(7, 6, 5, 4);
    in_rows[3] = pack4(3, 2, 1, 0);
    exp_q.push_back(pack4(0, 1, 2, 3));
    exp_q.push_back(pack4(4, 5, 6, 7));
    exp_q.push_back(pack4(8, 9, 10, 11));
    exp_q.push_back(pack4(12, 13, 14, 15));
    load_set(4, 0, 0, 1'b1);
    check("busy_rdy", 32'(bus.rdy), 32'd0);
    n = 0;
    while (!bus.output_enable && n < 20) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd6);
    wait_done();

    // Duplicates and extremes: one 00 among FFs.
    for (int i = 0; i < 16; i++) vals[i] = 8'hFF;
    vals[9] = 8'h00;
    vals_to_rows();
    exp_q.push_back(pack4(8'h00, 8'hFF, 8'hFF, 8'hFF));
    repeat (3) exp_q.push_back(pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF));
    load_set(4, 0, 0, 1'b1);
    wait_done();

    // Stall: 3 dead cycles in LOAD, 2 inside the output window.
    in_rows[0] = pack4(15, 14, 13, 12);
    in_rows[1] = pack4(11, 10, 9, 8);
    in_rows[2] = pack4(7, 6, 5, 4);
    in_rows[3] = pack4(3, 2, 1, 0);
    exp_q.push_back(pack4(0, 1, 2, 3));
    exp_q.push_back(pack4(4, 5, 6, 7));
    exp_q.push_back(pack4(8, 9, 10, 11));
    exp_q.push_back(pack4(12, 13, 14, 15));
    load_set(4, 3, 2, 1'b1);
    wait_done();

    // Start misuse: 1-cycle pulse still loads four rows.
    rises0 = oe_rises;
    for (int i = 0; i < 16; i++) vals[i] = W'((i * 37 + 11) % 256);
    vals_to_rows();
    push_sorted();
    load_set(1, 0, 0, 1'b1);
    wait_done();
    // Start pulse during SORT is ignored.
    for (int i = 0; i < 16; i++) vals[i] = W'(200 - i * 9);
    vals_to_rows();
    push_sorted();
    load_set(4, 0, 0, 1'b1);
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done();
    repeat (20) tick();
    check("misuse_windows", 32'(oe_rises - rises0), 32'd2);
    check("misuse_idle", 32'(bus.dbg_state), 32'd0);

    // Reset during SORT aborts with no output pulse.
    rises0 = oe_rises;
    for (int i = 0; i < 16; i++) vals[i] = W'(i * 5);
    vals_to_rows();
    load_set(4, 0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("abort_rdy", 32'(bus.rdy), 32'd1);
    check("abort_oe", 32'(bus.output_enable), 32'd0);
    check("abort_dout", bus.data_out, '0);
    tick();
    rst = 1'b1;
    repeat (20) tick();
    check("abort_no_pulse", 32'(oe_rises - rises0), 32'd0);

    // 100 random sets back-to-back; odd sets use a narrow range for ties.
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 16; i++)
        vals[i] = W'((k % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255));
      vals_to_rows();
      push_sorted();
      load_set(4, 0, 0, 1'b1);
    end
    wait_done();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("len_q_empty", 32'(len_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound in case a wait logic path misbehaves.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdsa_top.md
Name: mdsa_top

Overview:
- 4x4 multidimensional sorting array (MDSA) using bitonic compare-exchange networks.
- Loads 16 unsigned elements, one row per cycle, then runs shearsort-style row/column phases.
- Streams the 16 elements back out in ascending row-major order.
- Top-level sorter core; it sits between a loader and a result consumer and has a clock-enable for low-power stalling.

Parameters:
- W, 8, element width in bits (unsigned). The array is fixed at 4x4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable; 0 freezes every register (stall).
- start  in  1  request to begin a load; sampled only in IDLE.
- data_in  in  4*W  one row of 4 elements; element c (column c) at bits [W*c+W-1 : W*c].
- rdy  out  1  high when IDLE and able to accept start.
- output_enable  out  1  high while data_out carries a valid sorted row.
- data_out  out  4*W  one sorted row, same packing as data_in.

Behaviour:
- Reset (rst=0, async): state=IDLE, matrix cleared to 0, rdy=1, output_enable=0, data_out=0. Reset mid-operation aborts the sort; no partial output is produced.
- en=0: no state, counter, matrix or output register changes. A stalled cycle is invisible, so latency is counted in enabled edges only.
- States: IDLE -> LOAD -> SORT -> OUT -> IDLE.
- Edge 0 (first enabled edge with IDLE and start=1): capture data_in as row 0, rdy<=0, go to LOAD.
- LOAD: edges 1, 2 and 3 capture data_in as rows 1, 2 and 3 regardless of start level, then go to SORT.
  - start deasserting early does not shorten the load.
  - start held high past loading is ignored until rdy returns.
- SORT: edges 4-8, one phase per edge, all 4 lines processed in parallel by a 4-input bitonic network (3 compare-exchange stages, combinational). Phase order:
  - Edge 4 (R): rows; even rows ascending left-to-right, odd rows descending.
  - Edge 5 (C): columns, ascending top-to-bottom.
  - Edge 6 (R): same as edge 4.
  - Edge 7 (C): same as edge 5.
  - Edge 8 (R): same as edge 4, then go to OUT.
- After SORT the matrix is in snake order.
- OUT:
  - Edges 9-12 drive output_enable=1, with data_out = row r at edge 9+r.
  - Odd rows are reversed before output, so the concatenated stream is fully ascending.
  - Edge 13: output_enable<=0, data_out holds its last value, rdy<=1, state=IDLE.
- Latency: first valid row 9 enabled edges after edge 0. Total busy period is 13 edges; a new start is accepted from edge 13 on.
- Comparisons are unsigned. Equal values are permitted: ties swap or not with no observable difference.
- start in SORT or OUT is ignored.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> rdy=1, output_enable=0, data_out=0. Assert rst low during SORT -> immediate IDLE; no output_enable pulse follows.
- Reverse input: rows {15,14,13,12},{11,10,9,8},{7,6,5,4},{3,2,1,0}, start high 4 cycles -> output_enable high edges 9-12; rows out {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}; rdy=1 at edge 13.
- Duplicates and extremes (W=8): all 16 elements = 8'hFF except one 8'h00 -> first row {00,FF,FF,FF}, rest all FF.
- Random: 100 random 16-element sets loaded back-to-back (start re-asserted once rdy=1) -> each output stream equals the reference ascending sort.
- Stall: drop en for 3 cycles during LOAD and 2 during OUT -> same data as unstalled; output_enable stays high across the stall; the output window stretches by exactly the stalled cycles.
- Start misuse: pulse start 1 cycle only, and separately pulse start during SORT -> the 1-cycle pulse still loads 4 rows; the mid-sort pulse is ignored.
